pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Parametrised stall/flush controller for the in-order core pipeline. It generalises the fixed six-stage, fixed-priority stall/flush table to N stages and M request sources, with priority and masks set by parameter. It adds sequential behaviour:
- a post-reset flush sequence,
- a redirect-drain FSM that holds fetch while a fetch memory transaction is still outstanding after a jump or trap,
- a stall watchdog.

It sits beside the pipeline registers and drives their stall/flush inputs.

Parameters:
NUM_STAGES, 6, number of pipeline register stages; bit 0 = PC, bit NUM_STAGES-1 = MEM_WB.
NUM_REQ, 8, number of request sources; a higher index has higher priority.
STALL_MASKS, pkg default, NUM_REQ*NUM_STAGES bits; entry i sits at [i*NUM_STAGES +: NUM_STAGES].
FLUSH_MASKS, pkg default, same packing as STALL_MASKS.
REDIRECT_MASK, 8'b0010_1000, marks requests that redirect fetch (jump = 3, trap_flush = 5).
DRAIN_STALL, 6'b000011, stall applied while draining (PC + Pre_IF).
DRAIN_FLUSH, 6'b000100, flush applied while draining (IF_ID).
RST_CYCLES, 2, number of flush cycles after reset release.
TIMEOUT, 1024, consecutive PC-stall cycles before hang is flagged.

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous reset, active-low
req_i  in  NUM_REQ  stall/hazard requests (0 compress, 1 load_use, 2 mul_div, 3 jump, 4 trap_csr, 5 trap_flush, 6 if_ram, 7 mem_ram)
if_busy_i  in  1  fetch bus transaction outstanding
stall_o  out  NUM_STAGES  per-stage stall
flush_o  out  NUM_STAGES  per-stage flush
win_idx_o  out  $clog2(NUM_REQ)  index of the winning request; 0 when none
win_vld_o  out  1  a request won this cycle
draining_o  out  1  FSM is in DRAIN
hang_o  out  1  sticky watchdog flag

Behaviour:
- Clock and reset: single clock domain. Reset is asynchronous and active-low, named rst_n.
- FSM states: RST_FLUSH, RUN, DRAIN. Async reset forces RST_FLUSH, clears all counters and clears hang_o, including mid-operation.
- RST_FLUSH:
  - stall_o = 0, flush_o = all ones, win_vld_o = 0.
  - A counter runs for RST_CYCLES cycles after rst_n rises, then the FSM moves to RUN.
  - req_i is ignored in this state.
- Arbitration (RUN and DRAIN), combinational, zero latency:
  - w = highest set index of req_i.
  - base_stall = STALL_MASKS[w], base_flush = FLUSH_MASKS[w].
  - If req_i == 0, both are 0.
- RUN: stall_o = base_stall, flush_o = base_flush.
  - RUN -> DRAIN when win_vld_o, REDIRECT_MASK[w] and if_busy_i are all 1 at a clock edge.
  - If if_busy_i is 0 on the redirect cycle, the FSM stays in RUN.
- DRAIN:
  - stall_o = base_stall | DRAIN_STALL.
  - flush_o = (base_flush | DRAIN_FLUSH) & ~(base_stall | DRAIN_STALL); stall wins over flush in the same stage, except in RST_FLUSH.
  - Leaves to RUN on the first edge where if_busy_i = 0. That cycle still drives the drain masks, so the stale fetch response is discarded.
  - A new redirect while in DRAIN keeps the FSM in DRAIN; no re-entry pulse.
- RUN stall/flush overlap: if a mask table entry has stall and flush set on the same stage, flush wins for that stage.
- Watchdog:
  - cnt (width $clog2(TIMEOUT+1)) increments every cycle stall_o[0] = 1 and clears on any cycle stall_o[0] = 0.
  - cnt saturates at TIMEOUT.
  - hang_o is set the cycle after cnt reaches TIMEOUT and stays set until reset. The watchdog has no effect on stall/flush.
- Outputs are combinational from state and inputs; no input-to-output register stage.

Optional Feature:
PIPE_HAZARD_PERF_EN.
- Defined:
  - adds a NUM_REQ x 32-bit array of win counters; entry w increments on each cycle w wins, wrapping at 2^32;
  - adds input perf_sel_i ($clog2(NUM_REQ)) and output perf_cnt_o (32, combinational read);
  - the counters are cleared by reset.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package pipe_hazard_pkg:
  - request index localparams (REQ_COMPRESS ... REQ_MEM_RAM);
  - stage bit localparams (STG_PC ... STG_MEM_WB);
  - default STALL_MASKS and FLUSH_MASKS vectors;
  - FSM state enum.
- Default stall per request, 0..7: 000001, 000111, 000111, 000010, 111111, 000010, 011111, 011111.
- Default flush per request, 0..7: 000000, 001000, 010000, 001110, 001110, 001110, 000000, 100000.
- One sub-module, pipe_hazard_prio_enc: parametrised highest-index priority encoder producing w and win_vld_o.

Test Plan:
1. Reset: release rst_n -> flush_o = 6'b111111 and stall_o = 0 for exactly 2 cycles, then 0/0 with req_i = 0.
2. Priority: req_i = 8'b0000_1010 -> win_idx_o = 3, stall_o = 6'b000010, flush_o = 6'b001110; then req_i = 8'b1000_1010 -> win_idx_o = 7, stall_o = 6'b011111, flush_o = 6'b100000.
3. Drain: jump (req_i[3]) with if_busy_i = 1 for 3 cycles, req dropped after cycle 1:
   - draining_o = 1 for 3 cycles;
   - stall_o = 6'b000011 and flush_o = 6'b000100 on the cycles after the jump;
   - draining_o = 0 after if_busy_i falls.
4. Redirect with if_busy_i = 0 -> draining_o stays 0, masks as in scenario 2 for one cycle only.
5. Watchdog (TIMEOUT = 8 override): hold req_i[1] for 8 cycles -> hang_o rises on the next cycle; deassert req_i -> hang_o stays 1 until reset.
6. Async reset asserted mid-DRAIN -> draining_o = 0, flush_o = all ones immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: request and stage
// indices, default per-request stall/flush tables and the controller FSM states.
package pipe_hazard_pkg;

  localparam int REQ_COMPRESS   = 0;
  localparam int REQ_LOAD_USE   = 1;
  localparam int REQ_MUL_DIV    = 2;
  localparam int REQ_JUMP       = 3;
  localparam int REQ_TRAP_CSR   = 4;
  localparam int REQ_TRAP_FLUSH = 5;
  localparam int REQ_IF_RAM     = 6;
  localparam int REQ_MEM_RAM    = 7;

  localparam int STG_PC     = 0;
  localparam int STG_PRE_IF = 1;
  localparam int STG_IF_ID  = 2;
  localparam int STG_ID_EX  = 3;
  localparam int STG_EX_MEM = 4;
  localparam int STG_MEM_WB = 5;

  // Entry i occupies [i*6 +: 6]; listed from request 7 down to request 0.
  localparam logic [47:0] DEF_STALL_MASKS = {
    6'b011111, 6'b011111, 6'b000010, 6'b111111,
    6'b000010, 6'b000111, 6'b000111, 6'b000001
  };
  localparam logic [47:0] DEF_FLUSH_MASKS = {
    6'b100000, 6'b000000, 6'b001110, 6'b001110,
    6'b001110, 6'b010000, 6'b001000, 6'b000000
  };

  typedef enum logic [1:0] {
    RST_FLUSH,
    RUN,
    DRAIN
  } hz_state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Request/control bundle between the pipeline and its stall/flush controller.
// The perf-counter read port exists only when PIPE_HAZARD_PERF_EN is defined.
interface pipe_hazard_ctrl_if #(
  parameter int NUM_STAGES = 6,
  parameter int NUM_REQ    = 8
);
  import pipe_hazard_pkg::*;

  logic [NUM_REQ-1:0]        req_i;
  logic                      if_busy_i;
  logic [NUM_STAGES-1:0]     stall_o;
  logic [NUM_STAGES-1:0]     flush_o;
  logic [idx_w(NUM_REQ)-1:0] win_idx_o;
  logic                      win_vld_o;
  logic                      draining_o;
  logic                      hang_o;
`ifdef PIPE_HAZARD_PERF_EN
  logic [idx_w(NUM_REQ)-1:0] perf_sel_i;
  logic [31:0]               perf_cnt_o;
`endif

  // Pipeline side: raises requests, consumes stall/flush.
  modport master (
    output req_i, if_busy_i,
`ifdef PIPE_HAZARD_PERF_EN
    output perf_sel_i,
    input  perf_cnt_o,
`endif
    input  stall_o, flush_o, win_idx_o, win_vld_o, draining_o, hang_o
  );

  // Controller side.
  modport slave (
    input  req_i, if_busy_i,
`ifdef PIPE_HAZARD_PERF_EN
    input  perf_sel_i,
    output perf_cnt_o,
`endif
    output stall_o, flush_o, win_idx_o, win_vld_o, draining_o, hang_o
  );

endinterface

// File: rtl/pipe_hazard_ctrl_prio_enc.sv
// Highest-index-wins priority encoder; idx is 0 when no request is set.
module pipe_hazard_prio_enc import pipe_hazard_pkg::*; #(
  parameter int NUM_REQ = 8
) (
  input  logic [NUM_REQ-1:0]        req,
  output logic [idx_w(NUM_REQ)-1:0] idx,
  output logic                      vld
);

  localparam int IDX_W = idx_w(NUM_REQ);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    idx = '0;
    vld = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req[i]) begin
        idx = IDX_W'(i);
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Parametrised stall/flush controller: post-reset flush, fixed-priority arbitration,
// redirect drain FSM and stall watchdog. Optional win counters: PIPE_HAZARD_PERF_EN.
module pipe_hazard_ctrl import pipe_hazard_pkg::*; #(
  parameter int                              NUM_STAGES    = 6,
  parameter int                              NUM_REQ       = 8,
  parameter logic [NUM_REQ*NUM_STAGES-1:0]   STALL_MASKS   = DEF_STALL_MASKS,
  parameter logic [NUM_REQ*NUM_STAGES-1:0]   FLUSH_MASKS   = DEF_FLUSH_MASKS,
  parameter logic [NUM_REQ-1:0]              REDIRECT_MASK = 8'b0010_1000,
  parameter logic [NUM_STAGES-1:0]           DRAIN_STALL   = 6'b000011,
  parameter logic [NUM_STAGES-1:0]           DRAIN_FLUSH   = 6'b000100,
  parameter int                              RST_CYCLES    = 2,
  parameter int                              TIMEOUT       = 1024
) (
  input logic               clk,
  input logic               rst_n,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int IDX_W = idx_w(NUM_REQ);
  localparam int RC_W  = idx_w(RST_CYCLES + 1);
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  hz_state_e             state_q, state_d;
  logic [RC_W-1:0]       rst_cnt_q;
  logic [WD_W-1:0]       wd_cnt_q;
  logic                  hang_q;
  logic [IDX_W-1:0]      w;
  logic                  req_vld;
  logic [NUM_STAGES-1:0] base_stall, base_flush, stall, flush;
  logic                  rst_done;

  pipe_hazard_prio_enc #(.NUM_REQ(NUM_REQ)) u_prio_enc (
    .req (bus.req_i),
    .idx (w),
    .vld (req_vld)
  );

  assign base_stall = req_vld ? STALL_MASKS[w*NUM_STAGES +: NUM_STAGES] : '0;
  assign base_flush = req_vld ? FLUSH_MASKS[w*NUM_STAGES +: NUM_STAGES] : '0;
  assign rst_done   = (int'(rst_cnt_q) + 1 >= RST_CYCLES);

  // In RUN a stage may see both stall and flush; the pipeline register gives flush priority.
  always_comb begin
    state_d       = state_q;
    stall         = '0;
    flush         = '0;
    bus.win_vld_o = 1'b0;
    unique case (state_q)
      RST_FLUSH: begin
        flush = '1;
        if (rst_done) state_d = RUN;
      end
      RUN: begin
        stall         = base_stall;
        flush         = base_flush;
        bus.win_vld_o = req_vld;
        if (req_vld && REDIRECT_MASK[w] && bus.if_busy_i) state_d = DRAIN;
      end
      DRAIN: begin
        stall         = base_stall | DRAIN_STALL;
        flush         = (base_flush | DRAIN_FLUSH) & ~(base_stall | DRAIN_STALL);
        bus.win_vld_o = req_vld;
        if (!bus.if_busy_i) state_d = RUN;
      end
      default: state_d = RST_FLUSH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RST_FLUSH;
      rst_cnt_q <= '0;
      wd_cnt_q  <= '0;
      hang_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == RST_FLUSH && !rst_done) rst_cnt_q <= rst_cnt_q + 1'b1;
      if (!stall[0])                          wd_cnt_q  <= '0;
      else if (wd_cnt_q != WD_W'(TIMEOUT))    wd_cnt_q  <= wd_cnt_q + 1'b1;
      if (wd_cnt_q == WD_W'(TIMEOUT))         hang_q    <= 1'b1;
    end
  end

  assign bus.stall_o    = stall;
  assign bus.flush_o    = flush;
  assign bus.win_idx_o  = bus.win_vld_o ? w : '0;
  assign bus.draining_o = (state_q == DRAIN);
  assign bus.hang_o     = hang_q;

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] perf_cnt_q [NUM_REQ];

  // NOTE: this counter array is small and software reads it as a clean
  // statistic after reset, so every entry is cleared rather than left as RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) perf_cnt_q[i] <= '0;
    end else if (bus.win_vld_o) begin
      perf_cnt_q[w] <= perf_cnt_q[w] + 32'd1;
    end
  end

  assign bus.perf_cnt_o = perf_cnt_q[bus.perf_sel_i];
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (TIMEOUT overridden to 8).
module tb_pipe_hazard_ctrl;
  import pipe_hazard_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  pipe_hazard_ctrl_if #(.NUM_STAGES(6), .NUM_REQ(8)) hz_if ();

  pipe_hazard_ctrl #(.TIMEOUT(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (hz_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [7:0] req, input logic busy);
    hz_if.req_i     = req;
    hz_if.if_busy_i = busy;
    #1;
  endtask

  task automatic check_out(input string tag, input logic [5:0] st, input logic [5:0] fl,
                           input logic dr);
    check({tag, ".stall"}, 32'(hz_if.stall_o), 32'(st));
    check({tag, ".flush"}, 32'(hz_if.flush_o), 32'(fl));
    check({tag, ".drain"}, 32'(hz_if.draining_o), 32'(dr));
  endtask

  initial begin
    rst_n = 1'b0;
    drive(8'h00, 1'b0);
    tick();
    check_out("in_reset", 6'h00, 6'h3F, 1'b0);
    check("in_reset.hang", 32'(hz_if.hang_o), 32'd0);

    // Reset release: two flush cycles, requests ignored meanwhile.
    rst_n = 1'b1;
    drive(8'hFF, 1'b0);
    check_out("rst_cyc1", 6'h00, 6'h3F, 1'b0);
    check("rst_cyc1.vld", 32'(hz_if.win_vld_o), 32'd0);
    tick();
    drive(8'h00, 1'b0);
    check_out("rst_cyc2", 6'h00, 6'h3F, 1'b0);
    tick();
    check_out("run_idle", 6'h00, 6'h00, 1'b0);
    check("run_idle.vld", 32'(hz_if.win_vld_o), 32'd0);
    check("run_idle.idx", 32'(hz_if.win_idx_o), 32'd0);

    // Priority.
    drive(8'b0000_1010, 1'b0);
    check("prio_a.idx", 32'(hz_if.win_idx_o), 32'd3);
    check_out("prio_a", 6'b000010, 6'b001110, 1'b0);
    drive(8'b1000_1010, 1'b0);
    check("prio_b.idx", 32'(hz_if.win_idx_o), 32'd7);
    check("prio_b.vld", 32'(hz_if.win_vld_o), 32'd1);
    check_out("prio_b", 6'b011111, 6'b100000, 1'b0);
    drive(8'b0000_0001, 1'b0);
    check("prio_c.idx", 32'(hz_if.win_idx_o), 32'd0);
    check("prio_c.vld", 32'(hz_if.win_vld_o), 32'd1);
    tick();
    drive(8'h00, 1'b0);
    tick();

    // Non-redirect request with fetch busy stays in RUN.
    drive(8'b0000_0010, 1'b1);
    tick();
    drive(8'h00, 1'b1);
    check_out("nonredir_busy", 6'h00, 6'h00, 1'b0);
    drive(8'h00, 1'b0);
    tick();

    // Drain after jump with fetch busy.
    drive(8'b0000_1000, 1'b1);
    check_out("drain_run", 6'b000010, 6'b001110, 1'b0);
    tick();
    drive(8'h00, 1'b1);
    check_out("drain_c1", 6'b000011, 6'b000100, 1'b1);
    tick();
    drive(8'h00, 1'b1);
    check_out("drain_c2", 6'b000011, 6'b000100, 1'b1);
    tick();
    drive(8'h00, 1'b0);
    check_out("drain_c3", 6'b000011, 6'b000100, 1'b1);
    tick();
    check_out("drain_exit", 6'h00, 6'h00, 1'b0);

    // Redirect while draining: stays in DRAIN, stall beats flush per stage.
    drive(8'b0000_1000, 1'b1);
    tick();
    drive(8'b0000_1000, 1'b1);
    check_out("redrain_req", 6'b000011, 6'b001100, 1'b1);
    tick();
    drive(8'h00, 1'b0);
    check_out("redrain_last", 6'b000011, 6'b000100, 1'b1);
    tick();
    check_out("redrain_exit", 6'h00, 6'h00, 1'b0);

    // Trap redirect with fetch idle: one cycle of masks, no drain.
    drive(8'b0010_0000, 1'b0);
    check_out("redir_idle", 6'b000010, 6'b001110, 1'b0);
    tick();
    drive(8'h00, 1'b0);
    check_out("redir_idle_after", 6'h00, 6'h00, 1'b0);
    tick();

    // Watchdog: 7 stalled cycles then a gap must clear the count.
    drive(8'b0000_0010, 1'b0);
    for (int i = 0; i < 7; i++) tick();
    drive(8'h00, 1'b0);
    tick();
    drive(8'b0000_0010, 1'b0);
    for (int i = 0; i < 8; i++) tick();
    check("wd_at_timeout.hang", 32'(hz_if.hang_o), 32'd0);
    tick();
    check("wd_after.hang", 32'(hz_if.hang_o), 32'd1);
    check_out("wd_no_effect", 6'b000111, 6'b001000, 1'b0);
    drive(8'h00, 1'b0);
    tick();
    tick();
    check("wd_sticky.hang", 32'(hz_if.hang_o), 32'd1);

    // Async reset in the middle of DRAIN.
    drive(8'b0000_1000, 1'b1);
    tick();
    check("pre_async.drain", 32'(hz_if.draining_o), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("async_rst", 6'h00, 6'h3F, 1'b0);
    check("async_rst.hang", 32'(hz_if.hang_o), 32'd0);
    check("async_rst.vld", 32'(hz_if.win_vld_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
